// File: rtl/tpu_package.sv
// Shared constants and types for the systolic array front end.
// Array geometry and the data-setup FSM state encoding live here.
package tpu_package;

    localparam int ARRAY_DIM   = 32;
    localparam int DATA_W      = 8;
    localparam int ROW_CNT_W   = 5;
    localparam int DRAIN_CNT_W = $clog2(ARRAY_DIM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } setup_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the input skew: DEPTH register stages carrying data and valid together.
// SYSTOLIC_SETUP_ZERO_FLUSH_EN: stages load zero data whenever their incoming valid is low.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [DATA_W-1:0] data_in;
            logic              valid_in;
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            if (gi == 0) begin : g_head
                assign data_in  = data_i;
                assign valid_in = valid_i;
            end else begin : g_chain
                assign data_in  = g_stage[gi-1].data_reg;
                assign valid_in = g_stage[gi-1].valid_reg;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= valid_in;
`ifdef SYSTOLIC_SETUP_ZERO_FLUSH_EN
                    data_reg  <= valid_in ? data_in : '0;
`else
                    data_reg  <= data_in;
`endif
                end
            end
        end
    endgenerate

    assign data_o  = g_stage[DEPTH-1].data_reg;
    assign valid_o = g_stage[DEPTH-1].valid_reg;

endmodule

// File: rtl/systolic_data_setup.sv
// Skews unified-buffer rows onto the systolic array's left edge and tracks tile boundaries.
// Optional SYSTOLIC_SETUP_ZERO_FLUSH_EN zeroes lane data whenever that lane's valid is low.
module systolic_data_setup
    import tpu_package::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ub_read_en_i,
    input  logic [ARRAY_DIM*DATA_W-1:0] ub_rd_data_i,
    input  logic [ROW_CNT_W-1:0]        rows_per_tile_m1_i,
    output logic [ARRAY_DIM*DATA_W-1:0] array_data_o,
    output logic [ARRAY_DIM-1:0]        array_valid_o,
    output logic                        tile_done_o,
    output logic                        busy_o
);

    logic                   rd_valid_reg;
    logic [ROW_CNT_W-1:0]   row_cnt_reg;
    logic [ROW_CNT_W-1:0]   m1_reg;
    logic [ARRAY_DIM-1:0]   tag_reg;
    setup_state_e           state_reg, state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt_reg, drain_cnt_next;

    logic [ROW_CNT_W-1:0]   m1_eff;
    logic                   last_row;

    // The tile length is taken live on a tile's first row, then held for the rest of it.
    always_comb begin
        m1_eff   = (row_cnt_reg == '0) ? rows_per_tile_m1_i : m1_reg;
        last_row = rd_valid_reg && (row_cnt_reg == m1_eff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_reg <= 1'b0;
            row_cnt_reg  <= '0;
            m1_reg       <= '0;
            tag_reg      <= '0;
        end else begin
            rd_valid_reg <= ub_read_en_i;
            tag_reg      <= {tag_reg[ARRAY_DIM-2:0], last_row};
            if (rd_valid_reg) begin
                if (row_cnt_reg == '0) begin
                    m1_reg <= rows_per_tile_m1_i;
                end
                row_cnt_reg <= last_row ? '0 : row_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // DRAIN waits one array width for the last row's skew to empty unless a new tile starts.
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_valid_reg) begin
                    state_next     = last_row ? ST_DRAIN : ST_STREAM;
                    drain_cnt_next = '0;
                end
            end
            ST_STREAM: begin
                if (last_row) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                if (rd_valid_reg) begin
                    state_next     = last_row ? ST_DRAIN : ST_STREAM;
                    drain_cnt_next = '0;
                end else if (drain_cnt_reg == DRAIN_CNT_W'(ARRAY_DIM - 1)) begin
                    state_next     = ST_IDLE;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                drain_cnt_next = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
            skew_delay_line #(
                .DEPTH  (gi + 1),
                .DATA_W (DATA_W)
            ) u_lane (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .data_i  (ub_rd_data_i[gi*DATA_W +: DATA_W]),
                .valid_i (rd_valid_reg),
                .data_o  (array_data_o[gi*DATA_W +: DATA_W]),
                .valid_o (array_valid_o[gi])
            );
        end
    endgenerate

    assign tile_done_o = tag_reg[ARRAY_DIM-1];
    assign busy_o      = (state_reg != ST_IDLE) || (|array_valid_o);

endmodule

// File: tb/tb_systolic_data_setup.sv
// Bench for systolic_data_setup: a row-level model checked every cycle plus literal timing pins.
module tb_systolic_data_setup;
    import tpu_package::*;

    localparam int W    = ARRAY_DIM * DATA_W;
    localparam int HMAX = 1024;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           ub_read_en_i;
    logic [W-1:0]   ub_rd_data_i;
    logic [4:0]     rows_per_tile_m1_i;
    logic [W-1:0]   array_data_o;
    logic [ARRAY_DIM-1:0] array_valid_o;
    logic           tile_done_o;
    logic           busy_o;

    always #5 clk = ~clk;

    systolic_data_setup dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .ub_read_en_i       (ub_read_en_i),
        .ub_rd_data_i       (ub_rd_data_i),
        .rows_per_tile_m1_i (rows_per_tile_m1_i),
        .array_data_o       (array_data_o),
        .array_valid_o      (array_valid_o),
        .tile_done_o        (tile_done_o),
        .busy_o             (busy_o)
    );

    // Per-cycle record of what was driven; the model derives all outputs from it.
    int           cyc = 0;
    bit           rst_h  [HMAX];
    bit           rd_h   [HMAX];
    bit           last_h [HMAX];
    logic [W-1:0] d_h    [HMAX];
    logic [4:0]   m1_h   [HMAX];
    int           lr_h   [HMAX];

    int n_run  = 0;
    int n_fail = 0;
    int pos    = 0;
    logic [4:0] m1l = '0;
    int base   = 0;
    int done_q[$];
    int v0_q[$];

    localparam logic [W-1:0] JUNK = {ARRAY_DIM{8'h5A}};

    function automatic logic [W-1:0] row_word(input int r);
        logic [W-1:0] w;
        for (int k = 0; k < ARRAY_DIM; k++) w[k*DATA_W +: DATA_W] = 8'(r * 32 + k);
        return w;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic record();
        rst_h[cyc] = rst_i;
        rd_h[cyc]  = ub_read_en_i;
        d_h[cyc]   = ub_rd_data_i;
        m1_h[cyc]  = rows_per_tile_m1_i;
        lr_h[cyc]  = rst_i ? cyc : ((cyc == 0) ? -1 : lr_h[cyc-1]);
    endtask

    task automatic step(input bit rst, input bit rd, input logic [W-1:0] d, input logic [4:0] m);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", cyc, HMAX);
            $fatal(1);
        end
        rst_i              = rst;
        ub_read_en_i       = rd;
        ub_rd_data_i       = d;
        rows_per_tile_m1_i = m;
        record();
        if (tile_done_o)      done_q.push_back(cyc - base);
        if (array_valid_o[0]) v0_q.push_back(cyc - base);
    endtask

    task automatic start_test();
        base = cyc + 1;
        done_q.delete();
        v0_q.delete();
    endtask

    // Compare process: outputs seen in cycle c versus the row-level model.
    always @(negedge clk) begin : cmp
        int c, t;
        bit lastf, ed, eb;
        logic [ARRAY_DIM-1:0] ev;
        if (cyc >= 1) begin
            c = cyc;
            // Row read in cycle c-2 is accepted at the end of cycle c-1 unless reset intervenes.
            if (rst_h[c-1]) begin
                pos = 0;
            end else if (c >= 2 && rd_h[c-2] && !rst_h[c-2]) begin
                if (pos == 0) m1l = m1_h[c-1];
                lastf       = (pos == int'(m1l));
                last_h[c-2] = lastf;
                pos         = lastf ? 0 : pos + 1;
            end
            ev = '0;
            for (int k = 0; k < ARRAY_DIM; k++) begin
                t = c - k - 2;
                if (t >= 0 && rd_h[t] && lr_h[c-1] < t) ev[k] = 1'b1;
            end
            n_run++;
            if (array_valid_o !== ev) begin
                n_fail++;
                $display("FAIL valid c=%0d: got %h expected %h", c - base, array_valid_o, ev);
            end
            for (int k = 0; k < ARRAY_DIM; k++) begin
                t = c - k - 2;
                if (ev[k]) begin
                    n_run++;
                    if (array_data_o[k*DATA_W +: DATA_W] !== d_h[t+1][k*DATA_W +: DATA_W]) begin
                        n_fail++;
                        $display("FAIL data c=%0d lane=%0d: got %h expected %h", c - base, k,
                                 array_data_o[k*DATA_W +: DATA_W], d_h[t+1][k*DATA_W +: DATA_W]);
                    end
                end
`ifdef SYSTOLIC_SETUP_ZERO_FLUSH_EN
                else begin
                    n_run++;
                    if (array_data_o[k*DATA_W +: DATA_W] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL zero_flush c=%0d lane=%0d: got %h expected 00", c - base, k,
                                 array_data_o[k*DATA_W +: DATA_W]);
                    end
                end
`endif
            end
            t  = c - ARRAY_DIM - 1;
            ed = (t >= 0) && rd_h[t] && (lr_h[c-1] < t) && last_h[t];
            n_run++;
            if (tile_done_o !== ed) begin
                n_fail++;
                $display("FAIL tile_done c=%0d: got %b expected %b", c - base, tile_done_o, ed);
            end
            eb = (|ev) || (pos != 0);
            n_run++;
            if (busy_o !== eb) begin
                n_fail++;
                $display("FAIL busy c=%0d: got %b expected %b", c - base, busy_o, eb);
            end
        end
    end

    initial begin
        int bf;
        rst_i              = 1'b1;
        ub_read_en_i       = 1'b0;
        ub_rd_data_i       = JUNK;
        rows_per_tile_m1_i = 5'd0;
        record();

        // Reset with a read strobe in the last reset cycle: that read must be dropped.
        step(1, 0, JUNK, 5'd0);
        step(1, 0, JUNK, 5'd0);
        step(1, 1, JUNK, 5'd0);
        step(0, 0, JUNK, 5'd0);
        check("rst_valid", array_valid_o, 0);
        check("rst_data", (array_data_o == '0) ? 1 : 0, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", tile_done_o, 0);
        for (int r = 0; r < 40; r++) step(0, 0, JUNK, 5'd0);

        // Single 4-row tile.
        start_test();
        for (int r = 0; r < 50; r++) begin
            step(0, r < 4, (r >= 1 && r <= 4) ? row_word(r - 1) : JUNK, 5'd3);
            if (r == 8)  check("t1_lane5_row1", array_data_o[5*DATA_W +: DATA_W], 37);
            if (r == 36) check("t1_lane31_row3", array_data_o[31*DATA_W +: DATA_W], 127);
        end
        check("t1_done_count", done_q.size(), 1);
        check("t1_done_cycle", qat(done_q, 0), 36);

        // Two 2-row tiles back to back.
        start_test();
        bf = -1;
        for (int r = 0; r < 50; r++) begin
            step(0, r < 4, (r >= 1 && r <= 4) ? row_word(r - 1) : JUNK, 5'd1);
            if (r >= 5 && !busy_o && bf < 0) bf = r;
        end
        check("t2_done_count", done_q.size(), 2);
        check("t2_done_a", qat(done_q, 0), 34);
        check("t2_done_b", qat(done_q, 1), 36);
        check("t2_busy_fall", bf, 37);

        // 3-row tile with gaps: reads at 0, 2, 5.
        start_test();
        for (int r = 0; r < 50; r++) begin
            step(0, (r == 0 || r == 2 || r == 5),
                 (r == 1 || r == 3 || r == 6) ? row_word(r + 2) : JUNK, 5'd2);
        end
        check("t3_v0_count", v0_q.size(), 3);
        check("t3_v0_a", qat(v0_q, 0), 2);
        check("t3_v0_b", qat(v0_q, 1), 4);
        check("t3_v0_c", qat(v0_q, 2), 7);
        check("t3_done_count", done_q.size(), 1);
        check("t3_done_cycle", qat(done_q, 0), 38);

        // Reset in the middle of a 32-row tile, then a 1-row tile.
        start_test();
        for (int r = 0; r < 55; r++) begin
            step(r == 10, (r <= 10 || r == 15), (r >= 1 && r <= 11) || r == 16 ? row_word(r) : JUNK,
                 (r < 15) ? 5'd31 : 5'd0);
            if (r == 11) check("t4_valid_after_rst", array_valid_o, 0);
        end
        check("t4_done_count", done_q.size(), 1);
        check("t4_done_cycle", qat(done_q, 0), 48);

        // Tile length changed mid-tile, then two 1-row tiles.
        start_test();
        for (int r = 0; r < 50; r++) begin
            step(0, (r < 4 || r == 6 || r == 7), (r >= 1 && r <= 8) ? row_word(r) : JUNK,
                 (r < 3) ? 5'd3 : 5'd0);
        end
        check("t5_done_count", done_q.size(), 3);
        check("t5_done_a", qat(done_q, 0), 36);
        check("t5_done_b", qat(done_q, 1), 39);
        check("t5_done_c", qat(done_q, 2), 40);

        // All-0xFF single row.
        start_test();
        for (int r = 0; r < 40; r++) begin
            step(0, r == 0, {ARRAY_DIM{8'hFF}}, 5'd0);
            if (r == 2) check("t6_lane0_ff", array_data_o[0 +: DATA_W], 255);
`ifdef SYSTOLIC_SETUP_ZERO_FLUSH_EN
            if (r == 3) check("t6_lane0_flushed", array_data_o[0 +: DATA_W], 0);
`endif
        end
        check("t6_done_cycle", qat(done_q, 0), 33);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
